// File: rtl/bldc_pkg.sv
// bldc_pkg: shared state, command, drive and fault encodings for the BLDC drive sequencer.
package bldc_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_BRAKE = 3'd2,
        S_DEAD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;
    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_CW    = 2'b01,
        OP_CCW   = 2'b10,
        OP_BRAKE = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        F_NONE  = 2'b00,
        F_HALL  = 2'b01,
        F_STALL = 2'b10
    } fault_t;
    localparam logic [2:0] UI_COAST = 3'b000;
    localparam logic [2:0] UI_CW    = 3'b001;
    localparam logic [2:0] UI_CCW   = 3'b010;
    localparam logic [2:0] UI_BRAKE = 3'b100;
    function automatic logic hall_valid(input logic [2:0] h);
        return h != 3'b000 && h != 3'b111;
    endfunction
    function automatic logic [2:0] ui_of(input state_t s, input logic ccw);
        return s == S_RUN ? (ccw ? UI_CCW : UI_CW) : s == S_BRAKE ? UI_BRAKE : UI_COAST;
    endfunction
endpackage

// File: rtl/bldc_drive_sequencer_if.sv
// bldc_drive_sequencer_if: valid/ready command channel into the drive sequencer.
interface bldc_drive_sequencer_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    modport master(output cmd_valid, cmd_op, input cmd_ready);
    modport slave(input cmd_valid, cmd_op, output cmd_ready);
endinterface

// File: rtl/hall_debounce.sv
// hall_debounce: 2-flop synchronizer plus hold-time debounce of the raw hall sensors.
module hall_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] HS,
    output logic [2:0] hs_stable,
    output logic       hs_change
);
    localparam int W = $clog2(DEB_CYCLES + 1);
    logic [2:0]   s1, s2, cand;
    logic [W-1:0] cnt;
    logic         settle;
    // cnt is the number of consecutive samples cand has been seen on s2
    assign settle = s2 == cand && cnt == W'(DEB_CYCLES - 1) && cand != hs_stable;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            cand      <= '0;
            cnt       <= '0;
            hs_stable <= '0;
            hs_change <= 1'b0;
        end else begin
            s1        <= HS;
            s2        <= s1;
            cand      <= s2;
            cnt       <= s2 != cand ? W'(1) : cnt == W'(DEB_CYCLES) ? cnt : cnt + 1'b1;
            hs_stable <= settle ? cand : hs_stable;
            hs_change <= settle;
        end
    end
endmodule

// File: rtl/bldc_drive_sequencer.sv
// bldc_drive_sequencer: command-driven BLDC drive state machine with brake/dead-time
// sequencing on direction changes and hall-based fault supervision.
module bldc_drive_sequencer
    import bldc_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int BRAKE_CYCLES = 256,
    parameter int DEAD_CYCLES  = 16,
    parameter int STALL_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    bldc_drive_sequencer_if.slave  cmd,
    input  logic [2:0]             HS,
    output logic [2:0]             UI,
    output logic [2:0]             seq_state,
    output logic [1:0]             fault_code
);
    localparam int BW = $clog2(BRAKE_CYCLES + 1);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    state_t        state, nstate, tgt, ntgt;
    logic          dir, ndir;
    logic [1:0]    nfault;
    logic [BW-1:0] brk_cnt;
    logic [DW-1:0] dead_cnt;
    logic [SW-1:0] stall_cnt;
    logic [2:0]    hs_stable;
    logic          hs_change, xfer, hall_bad, stalled;
    hall_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk       (clk),
        .rst       (rst),
        .HS        (HS),
        .hs_stable (hs_stable),
        .hs_change (hs_change)
    );
    assign xfer      = cmd.cmd_valid && cmd.cmd_ready;
    assign hall_bad  = state inside {S_RUN, S_BRAKE, S_DEAD} && !hall_valid(hs_stable);
    assign stalled   = state == S_RUN && stall_cnt == SW'(STALL_CYCLES);
    assign seq_state = state;
    // faults outrank any command transferred in the same cycle
    always_comb begin
        nstate = state;
        ntgt   = tgt;
        ndir   = dir;
        nfault = fault_code;
        if (hall_bad) begin
            nstate = S_FAULT;
            nfault = F_HALL;
        end else if (stalled) begin
            nstate = S_FAULT;
            nfault = F_STALL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer && cmd.cmd_op inside {OP_CW, OP_CCW}) begin
                        nstate = S_RUN;
                        ndir   = cmd.cmd_op == OP_CCW;
                    end else if (xfer && cmd.cmd_op == OP_BRAKE) begin
                        nstate = S_BRAKE;
                        ntgt   = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (xfer && cmd.cmd_op inside {OP_STOP, OP_BRAKE}) begin
                        nstate = cmd.cmd_op == OP_STOP ? S_DEAD : S_BRAKE;
                        ntgt   = S_IDLE;
                    end else if (xfer && (cmd.cmd_op == OP_CCW) != dir) begin
                        nstate = S_BRAKE;
                        ntgt   = S_RUN;
                        ndir   = ~dir;
                    end
                end
                S_BRAKE: nstate = brk_cnt == BW'(BRAKE_CYCLES - 1) ? S_DEAD : S_BRAKE;
                S_DEAD:  nstate = dead_cnt == DW'(DEAD_CYCLES - 1) ? tgt : S_DEAD;
                S_FAULT: begin
                    if (xfer && cmd.cmd_op == OP_STOP) begin
                        nstate = S_IDLE;
                        nfault = F_NONE;
                    end
                end
                default: nstate = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            tgt           <= S_IDLE;
            dir           <= 1'b0;
            fault_code    <= F_NONE;
            UI            <= UI_COAST;
            cmd.cmd_ready <= 1'b1;
            brk_cnt       <= '0;
            dead_cnt      <= '0;
            stall_cnt     <= '0;
        end else begin
            state         <= nstate;
            tgt           <= ntgt;
            dir           <= ndir;
            fault_code    <= nfault;
            UI            <= ui_of(nstate, ndir);
            cmd.cmd_ready <= !(nstate inside {S_BRAKE, S_DEAD});
            brk_cnt       <= state == S_BRAKE && nstate == S_BRAKE ? brk_cnt + 1'b1 : '0;
            dead_cnt      <= state == S_DEAD && nstate == S_DEAD ? dead_cnt + 1'b1 : '0;
            stall_cnt     <= state == S_RUN && nstate == S_RUN && !hs_change ?
                             (stall_cnt == SW'(STALL_CYCLES) ? stall_cnt : stall_cnt + 1'b1) : '0;
        end
    end
endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// tb_bldc_drive_sequencer: directed scenarios for the BLDC drive sequencer (stall limit 50).
module tb_bldc_drive_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] HS  = 3'b000;
    logic [2:0] UI, seq_state;
    logic [1:0] fault_code;
    int         checks = 0;
    int         failures = 0;
    bldc_drive_sequencer_if cmd ();
    bldc_drive_sequencer #(
        .DEB_CYCLES(4), .BRAKE_CYCLES(256), .DEAD_CYCLES(16), .STALL_CYCLES(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .HS         (HS),
        .UI         (UI),
        .seq_state  (seq_state),
        .fault_code (fault_code)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input logic [1:0] op);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        tick(1);
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
    endtask
    task automatic start(input logic [2:0] h);
        rst = 1'b1;
        HS  = h;
        tick(2);
        rst = 1'b0;
        tick(8);
    endtask
    task automatic test_reset;
        HS = 3'b101;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = 2'b01;
        rst = 1'b1;
        tick(3);
        checks++; if (seq_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", seq_state); end
        checks++; if (UI !== 3'b000) begin failures++; $display("FAIL reset_ui got=%b exp=000", UI); end
        checks++; if (fault_code !== 2'b00) begin failures++; $display("FAIL reset_fault got=%b exp=00", fault_code); end
        checks++; if (cmd.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd.cmd_ready); end
        checks++; if (dut.hs_stable !== 3'b000) begin failures++; $display("FAIL reset_hs_stable got=%b exp=000", dut.hs_stable); end
        checks++; if (dut.stall_cnt !== '0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", dut.stall_cnt); end
        cmd.cmd_valid = 1'b0;
    endtask
    task automatic test_run_cw;
        start(3'b100);
        checks++; if (dut.hs_stable !== 3'b100) begin failures++; $display("FAIL cw_hs_stable got=%b exp=100", dut.hs_stable); end
        checks++; if (UI !== 3'b000) begin failures++; $display("FAIL cw_ui_before got=%b exp=000", UI); end
        send(2'b01);
        checks++; if (UI !== 3'b001) begin failures++; $display("FAIL cw_ui got=%b exp=001", UI); end
        checks++; if (seq_state !== 3'd1) begin failures++; $display("FAIL cw_state got=%0d exp=1", seq_state); end
    endtask
    task automatic test_dir_change;
        int bad;
        start(3'b100);
        send(2'b01);
        send(2'b10);
        checks++; if (UI !== 3'b100 || cmd.cmd_ready !== 1'b0) begin failures++; $display("FAIL dir_brake_entry ui=%b ready=%b exp ui=100 ready=0", UI, cmd.cmd_ready); end
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            tick(1);
            if (UI !== 3'b100 || cmd.cmd_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL dir_brake_hold bad_cycles=%0d exp=0", bad); end
        tick(1);
        checks++; if (UI !== 3'b000 || seq_state !== 3'd3) begin failures++; $display("FAIL dir_dead_entry ui=%b state=%0d exp ui=000 state=3", UI, seq_state); end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (UI !== 3'b000 || cmd.cmd_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL dir_dead_hold bad_cycles=%0d exp=0", bad); end
        tick(1);
        checks++; if (UI !== 3'b010 || seq_state !== 3'd1 || cmd.cmd_ready !== 1'b1) begin failures++; $display("FAIL dir_run_ccw ui=%b state=%0d ready=%b exp 010/1/1", UI, seq_state, cmd.cmd_ready); end
    endtask
    task automatic test_same_dir_and_stop;
        start(3'b100);
        send(2'b01);
        send(2'b01);
        checks++; if (UI !== 3'b001 || seq_state !== 3'd1) begin failures++; $display("FAIL same_dir ui=%b state=%0d exp 001/1", UI, seq_state); end
        send(2'b00);
        checks++; if (UI !== 3'b000 || seq_state !== 3'd3 || cmd.cmd_ready !== 1'b0) begin failures++; $display("FAIL stop_dead ui=%b state=%0d ready=%b exp 000/3/0", UI, seq_state, cmd.cmd_ready); end
        tick(15);
        checks++; if (seq_state !== 3'd3) begin failures++; $display("FAIL stop_dead_len state=%0d exp=3", seq_state); end
        tick(1);
        checks++; if (seq_state !== 3'd0 || cmd.cmd_ready !== 1'b1) begin failures++; $display("FAIL stop_idle state=%0d ready=%b exp 0/1", seq_state, cmd.cmd_ready); end
    endtask
    task automatic test_idle_brake;
        start(3'b100);
        send(2'b00);
        checks++; if (seq_state !== 3'd0) begin failures++; $display("FAIL idle_stop state=%0d exp=0", seq_state); end
        send(2'b11);
        checks++; if (UI !== 3'b100 || seq_state !== 3'd2) begin failures++; $display("FAIL idle_brake ui=%b state=%0d exp 100/2", UI, seq_state); end
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = 2'b01;
        tick(255);
        cmd.cmd_valid = 1'b0;
        checks++; if (seq_state !== 3'd2) begin failures++; $display("FAIL idle_brake_len state=%0d exp=2", seq_state); end
        tick(1);
        checks++; if (seq_state !== 3'd3) begin failures++; $display("FAIL idle_brake_dead state=%0d exp=3", seq_state); end
        tick(16);
        checks++; if (seq_state !== 3'd0 || UI !== 3'b000) begin failures++; $display("FAIL idle_brake_return state=%0d ui=%b exp 0/000", seq_state, UI); end
    endtask
    task automatic test_glitch;
        start(3'b100);
        send(2'b01);
        tick(2);
        HS = 3'b110;
        tick(3);
        HS = 3'b100;
        tick(6);
        checks++; if (dut.hs_stable !== 3'b100) begin failures++; $display("FAIL glitch_hs got=%b exp=100", dut.hs_stable); end
        checks++; if (dut.stall_cnt !== 6'd11) begin failures++; $display("FAIL glitch_stall got=%0d exp=11", dut.stall_cnt); end
        HS = 3'b110;
        tick(5);
        checks++; if (dut.hs_stable !== 3'b100) begin failures++; $display("FAIL hold3_hs got=%b exp=100", dut.hs_stable); end
        tick(1);
        checks++; if (dut.hs_stable !== 3'b110 || dut.stall_cnt !== 6'd17) begin failures++; $display("FAIL hold4_hs got=%b stall=%0d exp 110/17", dut.hs_stable, dut.stall_cnt); end
        tick(1);
        checks++; if (dut.stall_cnt !== 6'd0 || seq_state !== 3'd1) begin failures++; $display("FAIL edge_clear stall=%0d state=%0d exp 0/1", dut.stall_cnt, seq_state); end
    endtask
    task automatic test_invalid_hall;
        start(3'b100);
        send(2'b01);
        HS = 3'b111;
        tick(6);
        checks++; if (seq_state !== 3'd1) begin failures++; $display("FAIL inv_pre state=%0d exp=1", seq_state); end
        tick(1);
        checks++; if (seq_state !== 3'd4 || fault_code !== 2'b01 || UI !== 3'b000 || cmd.cmd_ready !== 1'b1) begin failures++; $display("FAIL inv_fault state=%0d fault=%b ui=%b ready=%b exp 4/01/000/1", seq_state, fault_code, UI, cmd.cmd_ready); end
        send(2'b01);
        send(2'b11);
        checks++; if (seq_state !== 3'd4 || fault_code !== 2'b01 || UI !== 3'b000) begin failures++; $display("FAIL inv_sticky state=%0d fault=%b ui=%b exp 4/01/000", seq_state, fault_code, UI); end
        send(2'b00);
        tick(3);
        checks++; if (seq_state !== 3'd0 || fault_code !== 2'b00) begin failures++; $display("FAIL inv_clear state=%0d fault=%b exp 0/00", seq_state, fault_code); end
    endtask
    task automatic test_fault_vs_cmd;
        start(3'b100);
        send(2'b01);
        HS = 3'b111;
        tick(6);
        send(2'b10);
        checks++; if (seq_state !== 3'd4 || UI !== 3'b000 || fault_code !== 2'b01) begin failures++; $display("FAIL fault_wins state=%0d ui=%b fault=%b exp 4/000/01", seq_state, UI, fault_code); end
    endtask
    task automatic test_stall;
        start(3'b011);
        send(2'b01);
        tick(50);
        checks++; if (seq_state !== 3'd1 || dut.stall_cnt !== 6'd50) begin failures++; $display("FAIL stall_pre state=%0d cnt=%0d exp 1/50", seq_state, dut.stall_cnt); end
        tick(1);
        checks++; if (seq_state !== 3'd4 || fault_code !== 2'b10 || UI !== 3'b000) begin failures++; $display("FAIL stall_fault state=%0d fault=%b ui=%b exp 4/10/000", seq_state, fault_code, UI); end
    endtask
    task automatic test_both_faults;
        start(3'b011);
        send(2'b01);
        tick(44);
        HS = 3'b111;
        tick(7);
        checks++; if (seq_state !== 3'd4 || fault_code !== 2'b01) begin failures++; $display("FAIL both_faults state=%0d fault=%b exp 4/01", seq_state, fault_code); end
    endtask
    task automatic test_rst_mid_brake;
        start(3'b100);
        send(2'b01);
        send(2'b10);
        tick(99);
        checks++; if (seq_state !== 3'd2) begin failures++; $display("FAIL rst_brake_pre state=%0d exp=2", seq_state); end
        rst = 1'b1;
        tick(1);
        checks++; if (UI !== 3'b000 || seq_state !== 3'd0 || cmd.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_brake ui=%b state=%0d ready=%b exp 000/0/1", UI, seq_state, cmd.cmd_ready); end
        rst = 1'b0;
    endtask
    initial begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        test_reset;
        test_run_cw;
        test_dir_change;
        test_same_dir_and_stop;
        test_idle_brake;
        test_glitch;
        test_invalid_hall;
        test_fault_vs_cmd;
        test_stall;
        test_both_faults;
        test_rst_mid_brake;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
